// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC owner, single-outstanding memory fetch, small FIFO to the core.
// Optional macro FETCH_TRACE_EN prints each delivered instruction and each redirect target.
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int                PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] RESET_PC_A = {RESET_PC[ADDR_W-1:2], 2'b00};

    localparam logic [0:0] ST_FETCH   = 1'b0;
    localparam logic [0:0] ST_DISCARD = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] old_addr_q, old_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0]       fifo_inst_q [DEPTH];
    logic [31:0]       fifo_inst_d [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_d   [DEPTH];

    logic in_fetch;
    logic req_int;
    logic push;
    logic pop;

    // DISCARD keeps the killed request alive on the bus until memory answers it.
    assign in_fetch   = (state_q == ST_FETCH);
    assign req_int    = in_fetch ? (count_q < DEPTH_C) : 1'b1;
    assign mem_req    = rst_n & req_int;
    assign mem_addr   = in_fetch ? fetch_pc_q : old_addr_q;
    assign inst_valid = (count_q != '0);
    assign inst       = fifo_inst_q[rd_ptr_q];
    assign inst_pc    = fifo_pc_q[rd_ptr_q];

    assign push = in_fetch & req_int & mem_ack & ~redirect;
    assign pop  = inst_valid & inst_ready & ~redirect;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        old_addr_d  = old_addr_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fifo_inst_d = fifo_inst_q;
        fifo_pc_d   = fifo_pc_q;

        if (push) begin
            fifo_inst_d[wr_ptr_q] = mem_rdata;
            fifo_pc_d[wr_ptr_q]   = fetch_pc_q;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            fetch_pc_d            = fetch_pc_q + ADDR_W'(4);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (!in_fetch && mem_ack) begin
            state_d = ST_FETCH;
        end

        // Redirect wins over push/pop/increment; a live unanswered request must be waited out.
        if (redirect) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            count_d    = '0;
            wr_ptr_d   = rd_ptr_q;
            rd_ptr_d   = rd_ptr_q;
            if (in_fetch && req_int && !mem_ack) begin
                state_d    = ST_DISCARD;
                old_addr_d = fetch_pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC_A;
            old_addr_q <= RESET_PC_A;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            old_addr_q  <= old_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_inst_q <= fifo_inst_d;
            fifo_pc_q   <= fifo_pc_d;
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (inst_valid && inst_ready) begin
                $display($time, " FETCH pc=%h inst=%b", inst_pc, inst);
            end
            if (redirect) begin
                $display($time, " REDIRECT pc=%h", {redirect_pc[ADDR_W-1:2], 2'b00});
            end
        end
    end
`else
    // Tracing compiled out.
`endif

endmodule
